// File: rtl/int_ctrl_pkg.sv
// Shared defaults, FSM state type and the priority encoder for the interrupt controller.
package int_ctrl_pkg;

    localparam int unsigned DefNSrc      = 4;
    localparam logic [31:0] DefVecBase   = 32'h0000_0200;
    localparam logic [31:0] DefVecStride = 32'h0000_0010;
    localparam int unsigned MaxSrc       = 32;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StFull
    } int_state_e;

    // Lowest set index among the first n bits of vec; n when none is set.
    function automatic int unsigned lowest_set(input logic [MaxSrc-1:0] vec,
                                               input int unsigned       n);
        int unsigned res;
        logic        found;
        res   = n;
        found = 1'b0;
        for (int unsigned i = 0; i < MaxSrc; i++) begin
            if (!found && (i < n) && vec[i]) begin
                res   = i;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/epc_stack.sv
// LIFO of return addresses; top reads zero when empty.
module epc_stack #(
    parameter int unsigned Depth  = 4,
    parameter int unsigned Width  = 32,
    localparam int unsigned DepthW = $clog2(Depth + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [Width-1:0]  push_data,
    output logic [Width-1:0]  top,
    output logic [DepthW-1:0] depth
);

    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [DepthW-1:0] depth_q;
    logic [IdxW-1:0]   push_idx;
    logic [IdxW-1:0]   top_idx;
    logic              empty;
    logic              full;

    always_comb begin
        empty    = (depth_q == '0);
        full     = (depth_q == DepthW'(Depth));
        push_idx = IdxW'(depth_q);
        top_idx  = IdxW'(depth_q - 1'b1);
        top      = empty ? '0 : mem_q[top_idx];
        depth    = depth_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !pop && !full) begin
            mem_q[push_idx] <= push_data;
            depth_q         <= depth_q + 1'b1;
        end else if (pop && !push && !empty) begin
            depth_q <= depth_q - 1'b1;
        end else if (push && pop && !empty) begin
            // Simultaneous push/pop replaces the top entry.
            mem_q[top_idx] <= push_data;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Nested, priority-ordered interrupt controller driving the fetch stage Int/Iaddr/EPC inputs.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC      = DefNSrc,
    parameter logic [31:0] VEC_BASE   = DefVecBase,
    parameter logic [31:0] VEC_STRIDE = DefVecStride
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             pc_en,
    input  logic [31:0]      redirect_pc,
    input  logic             eret_in,
    output logic             int_out,
    output logic [31:0]      iaddr,
    output logic [31:0]      epc,
    output logic [N_SRC-1:0] ack,
    output logic [N_SRC-1:0] in_service,
    output logic             eret_err
);

    localparam int unsigned DepthW = $clog2(N_SRC + 1);

    int_state_e        state_q, state_d;
    logic [N_SRC-1:0]  mask_q;
    logic [N_SRC-1:0]  in_service_q, in_service_d;
    logic              eret_err_q, eret_err_d;
    logic [N_SRC-1:0]  pending, eligible, take_oh, clr_oh;
    logic [MaxSrc-1:0] is_vec, elig_vec;
    int unsigned       cur_pri, winner;
    logic              push, pop;
    logic [DepthW-1:0] depth, depth_nxt;

    always_comb begin
        pending = irq_in & mask_q & ~in_service_q;

        is_vec                = '0;
        is_vec[N_SRC-1:0]     = in_service_q;
        cur_pri               = lowest_set(is_vec, N_SRC);

        // Only strictly higher-priority sources may preempt the active handler.
        eligible = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (i < cur_pri) eligible[i] = pending[i];
        end
        elig_vec              = '0;
        elig_vec[N_SRC-1:0]   = eligible;
        winner                = lowest_set(elig_vec, N_SRC);

        int_out = pc_en && (|eligible) && !eret_in;
        iaddr   = (|eligible) ? VEC_BASE + winner * VEC_STRIDE : VEC_BASE;
        push    = int_out;
        pop     = pc_en && eret_in && (state_q != StIdle);

        take_oh = '0;
        clr_oh  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            take_oh[i] = push && (i == winner);
            clr_oh[i]  = pop && (i == cur_pri);
        end
        ack = take_oh;

        in_service_d = (in_service_q | take_oh) & ~clr_oh;
        eret_err_d   = eret_err_q || (pc_en && eret_in && (state_q == StIdle));

        depth_nxt = depth + DepthW'(push) - DepthW'(pop);
        if (depth_nxt == '0) begin
            state_d = StIdle;
        end else if (depth_nxt == DepthW'(N_SRC)) begin
            state_d = StFull;
        end else begin
            state_d = StActive;
        end

        in_service = in_service_q;
        eret_err   = eret_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            in_service_q <= '0;
            eret_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_service_q <= in_service_d;
            eret_err_q   <= eret_err_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    epc_stack #(
        .Depth (N_SRC),
        .Width (32)
    ) u_epc_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (redirect_pc),
        .top       (epc),
        .depth     (depth)
    );

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4: number of interrupt sources; index 0 is highest priority.
REQ-002 The block SHALL have parameter VEC_BASE, default 32'h0000_0200: vector address of source 0.
REQ-003 The block SHALL have parameter VEC_STRIDE, default 32'h0000_0010: vector spacing per source.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 irq_in  in  N_SRC  level-sensitive interrupt requests.
REQ-007 mask_we  in  1  mask register write strobe.
REQ-008 mask_wdata  in  N_SRC  mask write data; 1 = source enabled.
REQ-009 pc_en  in  1  fetch PC advances this cycle.
REQ-010 redirect_pc  in  32  PC the fetch stage would load this cycle without interrupt (sequential, branch or jump target): the return address.
REQ-011 eret_in  in  1  ERET decoded this cycle.
REQ-012 int_out  out  1  take interrupt; drives fetch Int.
REQ-013 iaddr  out  32  vector of the taken source; drives fetch Iaddr.
REQ-014 epc  out  32  return address at top of EPC stack; drives fetch EPC.
REQ-015 ack  out  N_SRC  one-hot, one-cycle pulse marking the source taken.
REQ-016 in_service  out  N_SRC  registered in-service bits.
REQ-017 eret_err  out  1  sticky flag: ERET with empty stack.

Function
REQ-018 pending SHALL equal irq_in & mask & ~in_service.
REQ-019 cur_pri SHALL be the lowest set index of in_service, or N_SRC when in_service is zero.
REQ-020 eligible SHALL be pending bits with index < cur_pri; winner SHALL be the lowest eligible index.
REQ-021 int_out SHALL be combinational: high iff pc_en=1, eligible nonzero, eret_in=0.
REQ-022 iaddr SHALL equal VEC_BASE + winner*VEC_STRIDE whenever eligible is nonzero, else VEC_BASE.
REQ-023 On an edge with int_out=1, the block SHALL push redirect_pc, set in_service[winner] and pulse ack[winner] in that cycle; latency request-to-int_out is zero cycles when pc_en=1.
REQ-024 States SHALL be IDLE (depth 0), ACTIVE (1..N_SRC-1), FULL (depth N_SRC); take increments depth, accepted ERET decrements it.
REQ-025 Higher-priority eligible requests SHALL preempt an in-service handler (nesting); equal or lower priority SHALL wait.
REQ-026 epc SHALL be combinational top of stack; 0 when depth=0.
REQ-027 ERET with pc_en=1 and depth>0 SHALL pop the stack and clear in_service[cur_pri] at the edge.
REQ-028 ERET with pc_en=1 and depth=0 SHALL leave state unchanged and set eret_err.
REQ-029 eret_in=1 together with an eligible request SHALL complete ERET first; the interrupt is taken on the next pc_en cycle (tail chain), returning to the popped epc.
REQ-030 pc_en=0 SHALL freeze stack, in_service and ack (ack=0); eret_in is ignored.
REQ-031 mask_we SHALL update mask at the edge; a masked source already in service SHALL stay in service until ERET.
REQ-032 Push at depth N_SRC SHALL be impossible (no eligible source exists) and need no overflow path.

Reset
REQ-033 rst_n=0 SHALL immediately clear mask, in_service, depth, stack contents, eret_err; int_out=0, ack=0, epc=0, iaddr=VEC_BASE.
REQ-034 Reset mid-handler SHALL discard all nesting; no ERET is required afterwards.

Structure
REQ-035 N_SRC, VEC_BASE, VEC_STRIDE defaults and the priority-encode function SHALL live in shared package int_ctrl_pkg.
REQ-036 The EPC LIFO SHALL be a sub-module epc_stack (depth N_SRC, width 32, push/pop/top/depth).

Verification
REQ-037 Mask=4'b0100, irq_in[2]=1, pc_en=1, redirect_pc=0x40 -> int_out=1, iaddr=0x220, ack=4'b0100; next cycle epc=0x40, in_service=4'b0100.
REQ-038 In service src2, assert irq_in[0] (mask 4'b0101), redirect_pc=0x228 -> iaddr=0x200, depth 2, epc=0x228; ERET -> epc=0x40, in_service=4'b0100.
REQ-039 In service src1, irq_in[3] asserted -> int_out stays 0 until ERET completes, then src3 taken next pc_en cycle.
REQ-040 eret_in and eligible irq same cycle -> int_out=0, pop happens; next cycle int_out=1 with redirect_pc saved.
REQ-041 ERET at depth 0 -> eret_err=1, in_service unchanged; pc_en=0 with pending irq -> int_out=0, no state change.
REQ-042 rst_n low at depth 2 -> in_service=0, epc=0, mask=0 asynchronously, before the next clk edge.
